// File: rtl/time_entry_ctrl_pkg.sv
// Shared definitions for the microwave time-entry controller: FSM encoding,
// default key codes and BCD digit width.
package time_entry_ctrl_pkg;

  localparam int BCD_W = 4;
  localparam int NDIG  = 4;

  localparam logic [BCD_W-1:0] KEY_START_DEF = 4'hA;
  localparam logic [BCD_W-1:0] KEY_STOP_DEF  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/time_entry_ctrl_buffer.sv
// Four-digit BCD entry buffer: shifts digits in from the right while the
// leading digit is still zero, and flags empty / seconds-in-range.
module bcd_entry_buffer
  import time_entry_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_i,
  input  logic                       clear_i,
  input  logic [BCD_W-1:0]           digit_i,
  output logic [NDIG-1:0][BCD_W-1:0] digits_o,
  output logic                       zero_o,
  output logic                       valid_o
);

  // [3]=min_tens, [2]=min_ones, [1]=sec_tens, [0]=sec_ones
  logic [NDIG-1:0][BCD_W-1:0] digits_q, digits_d;
  logic                       full;

  assign full = (digits_q[3] != '0);

  always_comb begin
    digits_d = digits_q;
    if (clear_i)
      digits_d = '0;
    else if (shift_i && !full)
      digits_d = {digits_q[2:0], digit_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digits_q <= '0;
    else     digits_q <= digits_d;
  end

  assign digits_o = digits_q;
  assign zero_o   = (digits_q == '0);
  assign valid_o  = (digits_q[1] <= 4'd5);

endmodule

// File: rtl/time_entry_ctrl.sv
// Microwave time-entry FSM: collects BCD digits, loads and runs the external
// mod-10/mod-6 timer chain, and handles pause, cancel and completion.
module time_entry_ctrl
  import time_entry_ctrl_pkg::*;
#(
  parameter logic [BCD_W-1:0] KEY_START = KEY_START_DEF,
  parameter logic [BCD_W-1:0] KEY_STOP  = KEY_STOP_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_code,
  input  logic             door_closed,
  input  logic             timer_zero,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             loadn,
  output logic             timer_clrn,
  output logic             timer_en,
  output logic             done,
  output logic             err,
  output logic [2:0]       state
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   clrp_q, clrp_d;
  logic   buf_shift, buf_clear, buf_zero, buf_valid;
  logic   key_start, key_stop, key_digit;
  logic [NDIG-1:0][BCD_W-1:0] digits;

  assign key_start = key_valid && (key_code == KEY_START);
  assign key_stop  = key_valid && (key_code == KEY_STOP);
  assign key_digit = key_valid && is_digit(key_code);

  bcd_entry_buffer u_buf (
    .clk      (clk),
    .rst      (clr),
    .shift_i  (buf_shift),
    .clear_i  (buf_clear),
    .digit_i  (key_code),
    .digits_o (digits),
    .zero_o   (buf_zero),
    .valid_o  (buf_valid)
  );

  // Strobe flags reset low so a reset release never emits a load/clear pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      clrp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      clrp_q  <= clrp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_shift = 1'b0;
    buf_clear = 1'b0;
    err_d     = 1'b0;
    clrp_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_digit)
          buf_shift = 1'b1;
        else if (key_stop)
          buf_clear = 1'b1;
        else if (key_start) begin
          if (door_closed && !buf_zero && buf_valid) state_d = ST_LOAD;
          else                                       err_d   = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        // Expiry wins over a simultaneous stop or door opening.
        if (timer_zero)                  state_d = ST_DONE;
        else if (key_stop || !door_closed) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (key_start) begin
          if (door_closed) state_d = ST_RUN;
          else             err_d   = 1'b1;
        end else if (key_stop) begin
          state_d   = ST_IDLE;
          buf_clear = 1'b1;
          clrp_d    = 1'b1;
        end
      end
      ST_DONE: begin
        if (key_valid || !door_closed) begin
          state_d   = ST_IDLE;
          buf_clear = 1'b1;
          clrp_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    loadn      = (state_q != ST_LOAD);
    timer_en   = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    timer_clrn = !clrp_q;
    err        = err_q;
    state      = state_q;
    min_tens   = digits[3];
    min_ones   = digits[2];
    sec_tens   = digits[1];
    sec_ones   = digits[0];
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl: entry, load/run, pause/cancel, done,
// error pulses and asynchronous reset.
module tb_time_entry_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_valid;
  logic [3:0] key_code;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, timer_clrn, timer_en, done, err;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  localparam logic [3:0] K_START = 4'hA;
  localparam logic [3:0] K_STOP  = 4'hB;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2,
                         S_PAUSE = 3'd3, S_DONE = 3'd4;

  always #5 clk = ~clk;

  time_entry_ctrl dut (
    .clk         (clk),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .loadn       (loadn),
    .timer_clrn  (timer_clrn),
    .timer_en    (timer_en),
    .done        (done),
    .err         (err),
    .state       (state)
  );

  wire [15:0] digs = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the key edge.
  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  initial begin
    clr = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    door_closed = 1'b1; timer_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, S_IDLE);
    chk("rst_digs", digs, 16'h0000);
    chk("rst_strobes", {loadn, timer_clrn, timer_en, done, err}, 5'b11000);
    clr = 1'b0;

    // Entry 1,3,0 then start: first key lands on first edge after reset.
    key(4'd1);
    chk("first_key", digs, 16'h0001);
    key(4'd3); key(4'd0);
    chk("entry_130", digs, 16'h0130);
    key(K_START);
    chk("load_state", state, S_LOAD);
    chk("load_loadn", loadn, 1'b0);
    chk("load_en", timer_en, 1'b0);
    @(negedge clk);
    chk("run_state", state, S_RUN);
    chk("run_loadn", loadn, 1'b1);
    chk("run_en", timer_en, 1'b1);

    // Pause, resume without reload, cancel.
    key(K_STOP);
    chk("pause_state", state, S_PAUSE);
    chk("pause_en", timer_en, 1'b0);
    key(K_START);
    chk("resume_state", state, S_RUN);
    chk("resume_loadn", loadn, 1'b1);
    chk("resume_digs", digs, 16'h0130);
    key(K_STOP);
    key(K_STOP);
    chk("cancel_state", state, S_IDLE);
    chk("cancel_digs", digs, 16'h0000);
    chk("cancel_clrn", timer_clrn, 1'b0);
    @(negedge clk);
    chk("cancel_clrn_end", timer_clrn, 1'b1);

    // Overflow drop, idle stop, invalid seconds, empty buffer, open door.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("overflow_drop", digs, 16'h1234);
    key(K_STOP);
    chk("idle_stop_digs", digs, 16'h0000);
    chk("idle_stop_clrn", timer_clrn, 1'b1);
    key(4'd0); key(4'd7); key(4'd0);
    chk("entry_070", digs, 16'h0070);
    key(K_START);
    chk("bad_sec_err", err, 1'b1);
    chk("bad_sec_state", state, S_IDLE);
    @(negedge clk);
    chk("bad_sec_err_end", err, 1'b0);
    key(K_STOP);
    key(K_START);
    chk("zero_err", err, 1'b1);
    key(4'd1); key(4'd0);
    door_closed = 1'b0;
    key(K_START);
    chk("door_err", {err, state}, {1'b1, S_IDLE});
    door_closed = 1'b1;
    key(4'hC);
    chk("ignored_code", {err, digs}, {1'b0, 16'h0010});

    // Expiry beats simultaneous stop; any key then leaves DONE.
    key(K_START);
    @(negedge clk);
    timer_zero = 1'b1;
    key(K_STOP);
    timer_zero = 1'b0;
    chk("done_state", state, S_DONE);
    chk("done_flag", {done, timer_en}, 2'b10);
    chk("done_digs", digs, 16'h0010);
    key(4'd5);
    chk("done_exit", {state, done, timer_clrn}, {S_IDLE, 1'b0, 1'b0});
    chk("done_exit_digs", digs, 16'h0000);

    // Door opens mid-run, resume attempt with door open, then reset mid-run.
    key(4'd2);
    key(K_START);
    @(negedge clk);
    door_closed = 1'b0;
    @(negedge clk);
    chk("door_pause", state, S_PAUSE);
    key(K_START);
    chk("pause_door_err", {err, state}, {1'b1, S_PAUSE});
    door_closed = 1'b1;
    key(K_START);
    chk("door_resume", {state, timer_en}, {S_RUN, 1'b1});
    #2 clr = 1'b1;
    #1;
    chk("async_rst", {state, timer_en, loadn, timer_clrn, done, err}, {S_IDLE, 5'b01100});
    chk("async_rst_digs", digs, 16'h0000);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_release", {loadn, timer_clrn, timer_en}, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
